// File: rtl/mips_pipe_core_p.sv
// mips_pipe_core_p: parametrised 5-stage MIPS pipeline with memory wait states,
// selectable forwarding or interlock, HALT drain FSM and a retire trace port.
module mips_pipe_core_p #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          FWD_EN   = 1,
    parameter int          DMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ready,
    output logic               retire_valid,
    output logic [31:0]        retire_pc,
    output logic               halted
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02, OP_HALT = 6'h3F;

    state_t state, state_nx;
    logic [31:0] pc;
    logic        ifid_v;
    logic [31:0] ifid_pc, ifid_ir;
    logic        idex_v;
    logic [31:0] idex_pc, idex_ir, idex_a, idex_b;
    logic [4:0]  idex_dst;
    logic        exm_v, exm_re, exm_we, exm_halt;
    logic [31:0] exm_pc, exm_res, exm_sd;
    logic [4:0]  exm_dst;
    logic        wb_v;
    logic [31:0] wb_pc, wb_data;
    logic [4:0]  wb_dst;
    logic [31:0] rf [32];

    logic [5:0]  id_op, id_fn, ex_op, ex_fn;
    logic [4:0]  id_rs, id_rt, id_dst, ex_rs, ex_rt;
    logic        id_r, id_legal, id_use_rs, id_use_rt, halt_id, wb_wr;
    logic        ex_hit, mem_hit, load_use, stall_id, mem_wait, take, fetch_en;
    logic [31:0] id_a, id_b, ex_a, ex_b, ex_imm, ex_res, ex_pc4, target;

    always_comb begin
        id_op     = ifid_ir[31:26];
        id_fn     = ifid_ir[5:0];
        id_rs     = ifid_ir[25:21];
        id_rt     = ifid_ir[20:16];
        id_r      = id_op == OP_R && id_fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        id_legal  = id_r || id_op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_HALT};
        id_dst    = id_r ? ifid_ir[15:11] : (id_op == OP_LW || id_op == OP_ADDI) ? id_rt : 5'd0;
        id_use_rs = id_r || id_op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI};
        id_use_rt = id_r || id_op inside {OP_SW, OP_BEQ, OP_BNE};
        halt_id   = ifid_v && id_op == OP_HALT;
        // rf[0] is never written, so r0 reads zero without a special case
        wb_wr     = wb_v && wb_dst != 5'd0;
        id_a      = (wb_wr && wb_dst == id_rs) ? wb_data : rf[id_rs];
        id_b      = (wb_wr && wb_dst == id_rt) ? wb_data : rf[id_rt];
        ex_hit    = idex_v && idex_dst != 5'd0 &&
                    ((id_use_rs && idex_dst == id_rs) || (id_use_rt && idex_dst == id_rt));
        mem_hit   = exm_v && exm_dst != 5'd0 &&
                    ((id_use_rs && exm_dst == id_rs) || (id_use_rt && exm_dst == id_rt));
        load_use  = ex_hit && idex_ir[31:26] == OP_LW;
        stall_id  = ifid_v && (FWD_EN != 0 ? load_use : (ex_hit || mem_hit));
    end

    always_comb begin
        ex_op  = idex_ir[31:26];
        ex_fn  = idex_ir[5:0];
        ex_rs  = idex_ir[25:21];
        ex_rt  = idex_ir[20:16];
        ex_imm = {{16{idex_ir[15]}}, idex_ir[15:0]};
        // MEM result takes priority over WB when both hold the source register
        ex_a   = (FWD_EN != 0 && exm_v && exm_dst != 5'd0 && exm_dst == ex_rs) ? exm_res :
                 (FWD_EN != 0 && wb_wr && wb_dst == ex_rs) ? wb_data : idex_a;
        ex_b   = (FWD_EN != 0 && exm_v && exm_dst != 5'd0 && exm_dst == ex_rt) ? exm_res :
                 (FWD_EN != 0 && wb_wr && wb_dst == ex_rt) ? wb_data : idex_b;
        ex_res = ex_op != OP_R   ? ex_a + ex_imm :
                 ex_fn == 6'h22  ? ex_a - ex_b :
                 ex_fn == 6'h24  ? ex_a & ex_b :
                 ex_fn == 6'h25  ? ex_a | ex_b :
                 ex_fn == 6'h2A  ? {31'd0, $signed(ex_a) < $signed(ex_b)} : ex_a + ex_b;
        ex_pc4 = idex_pc + 32'd4;
        take   = idex_v && ((ex_op == OP_BEQ && ex_a == ex_b) ||
                            (ex_op == OP_BNE && ex_a != ex_b) || ex_op == OP_J);
        target = ex_op == OP_J ? {ex_pc4[31:28], idex_ir[25:0], 2'b00} : ex_pc4 + (ex_imm << 2);
    end

    assign dmem_re      = exm_v && exm_re;
    assign dmem_we      = exm_v && exm_we;
    assign dmem_addr    = exm_res[DMEM_AW+1:2];
    assign dmem_wdata   = exm_sd;
    assign mem_wait     = (dmem_re || dmem_we) && !dmem_ready;
    assign fetch_en     = state == RUN && !halt_id && imem_valid;
    assign imem_addr    = pc;
    assign retire_valid = wb_v;
    assign retire_pc    = wb_pc;
    assign halted       = state == HALTED;

    always_comb begin
        state_nx = state;
        if (state == RUN)
            state_nx = (halt_id && !mem_wait && !take) ? DRAIN : RUN;
        else if (state == DRAIN)
            state_nx = (!mem_wait && take) ? RUN : (exm_v && exm_halt) ? HALTED : DRAIN;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= RUN;
        else state <= state_nx;

    always_ff @(posedge clk or negedge reset)
        if (!reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
        else if (wb_wr) rf[wb_dst] <= wb_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            ifid_v   <= 1'b0;
            ifid_pc  <= '0;
            ifid_ir  <= '0;
            idex_v   <= 1'b0;
            idex_pc  <= '0;
            idex_ir  <= '0;
            idex_a   <= '0;
            idex_b   <= '0;
            idex_dst <= '0;
            exm_v    <= 1'b0;
            exm_re   <= 1'b0;
            exm_we   <= 1'b0;
            exm_halt <= 1'b0;
            exm_pc   <= '0;
            exm_res  <= '0;
            exm_sd   <= '0;
            exm_dst  <= '0;
            wb_v     <= 1'b0;
            wb_pc    <= '0;
            wb_data  <= '0;
            wb_dst   <= '0;
        end else if (!mem_wait) begin
            pc <= take ? target : (stall_id || !fetch_en) ? pc : pc + 32'd4;
            if (take) begin
                ifid_v <= 1'b0;
            end else if (!stall_id) begin
                ifid_v  <= fetch_en;
                ifid_pc <= pc;
                ifid_ir <= imem_rdata;
            end
            idex_v   <= ifid_v && id_legal && !take && !stall_id;
            idex_pc  <= ifid_pc;
            idex_ir  <= ifid_ir;
            idex_a   <= id_a;
            idex_b   <= id_b;
            idex_dst <= id_dst;
            exm_v    <= idex_v;
            exm_pc   <= idex_pc;
            exm_res  <= ex_res;
            exm_sd   <= ex_b;
            exm_dst  <= idex_dst;
            exm_re   <= ex_op == OP_LW;
            exm_we   <= ex_op == OP_SW;
            exm_halt <= ex_op == OP_HALT;
            wb_v     <= exm_v;
            wb_pc    <= exm_pc;
            wb_dst   <= exm_dst;
            wb_data  <= exm_re ? dmem_rdata : exm_res;
        end else begin
            // Frozen EX keeps its forwarded operands since WB drains to a bubble
            idex_a <= ex_a;
            idex_b <= ex_b;
            wb_v   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_pipe_core_p.sv
// tb_mips_pipe_core_p: directed program tests on a forwarding core and an interlock-only core.
module tb_mips_pipe_core_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ivalid, wait_en;
    logic [31:0] imem [256];
    logic [31:0] ia0, ird0, dwd0, drd0, rpc0, ia1, ird1, dwd1, drd1, rpc1;
    logic [9:0]  da0, da1;
    logic        dwe0, dre0, rdy0, rv0, h0, dwe1, dre1, rdy1, rv1, h1;
    logic [31:0] dm0 [1024];
    logic [31:0] dm1 [1024];
    int          cyc = 0, wcnt, checks = 0, errors = 0;
    int          rc0 [64];
    int          rc1 [64];
    int          wait_cyc, re_cyc, frz_bad;
    logic [31:0] pc_snap, halt_rpc;
    logic        halt_seen, halt_rv;

    mips_pipe_core_p #(.RESET_PC(32'h0), .FWD_EN(1), .DMEM_AW(10)) u_fwd (
        .clk(clk), .reset(reset), .imem_addr(ia0), .imem_rdata(ird0), .imem_valid(ivalid),
        .dmem_addr(da0), .dmem_wdata(dwd0), .dmem_we(dwe0), .dmem_re(dre0), .dmem_rdata(drd0),
        .dmem_ready(rdy0), .retire_valid(rv0), .retire_pc(rpc0), .halted(h0));
    mips_pipe_core_p #(.RESET_PC(32'h0), .FWD_EN(0), .DMEM_AW(10)) u_ilk (
        .clk(clk), .reset(reset), .imem_addr(ia1), .imem_rdata(ird1), .imem_valid(ivalid),
        .dmem_addr(da1), .dmem_wdata(dwd1), .dmem_we(dwe1), .dmem_re(dre1), .dmem_rdata(drd1),
        .dmem_ready(rdy1), .retire_valid(rv1), .retire_pc(rpc1), .halted(h1));

    assign ird0 = imem[ia0[9:2]];
    assign ird1 = imem[ia1[9:2]];
    assign drd0 = dm0[da0];
    assign drd1 = dm1[da1];
    assign rdy0 = !(wait_en && dre0 && wcnt < 3);
    assign rdy1 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) begin
                dm0[i] <= '0;
                dm1[i] <= '0;
            end
            wcnt <= 0;
        end else begin
            if (dwe0 && rdy0) dm0[da0] <= dwd0;
            if (dwe1 && rdy1) dm1[da1] <= dwd1;
            if (dre0 && !rdy0) wcnt <= wcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                rc0[i] <= -1;
                rc1[i] <= -1;
            end
            wait_cyc  <= 0;
            re_cyc    <= 0;
            frz_bad   <= 0;
            halt_seen <= 1'b0;
            halt_rv   <= 1'b0;
            halt_rpc  <= '0;
        end else begin
            if (rv0) rc0[rpc0[7:2]] <= cyc;
            if (rv1) rc1[rpc1[7:2]] <= cyc;
            if (dre0) re_cyc <= re_cyc + 1;
            if (dre0 && !rdy0) begin
                if (wait_cyc == 0) pc_snap <= ia0;
                else if (ia0 != pc_snap) frz_bad <= frz_bad + 1;
                wait_cyc <= wait_cyc + 1;
            end
            if (h0 && !halt_seen) begin
                halt_seen <= 1'b1;
                halt_rv   <= rv0;
                halt_rpc  <= rpc0;
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] d, s, t);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] t, s,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    localparam logic [31:0] HALT = 32'hFC00_0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = h0 && h1;
        end
        chk({nm, "_halt_reached"}, {31'd0, ok}, 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] i0, i1, i2, exp;
    } vec_t;
    vec_t vt [13];

    initial begin
        vt[0]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'd5),     enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD),
                   enc_r(6'h20, 5'd3, 5'd1, 5'd2),       32'd2};
        vt[1]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'd0),     enc_i(6'h08, 5'd2, 5'd0, 16'd1),
                   enc_r(6'h22, 5'd3, 5'd1, 5'd2),       32'hFFFF_FFFF};
        vt[2]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'h0F0F),  enc_i(6'h08, 5'd2, 5'd0, 16'h00FF),
                   enc_r(6'h24, 5'd3, 5'd1, 5'd2),       32'h0000_000F};
        vt[3]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'h0F00),  enc_i(6'h08, 5'd2, 5'd0, 16'h00F0),
                   enc_r(6'h25, 5'd3, 5'd1, 5'd2),       32'h0000_0FF0};
        vt[4]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'hFFFD),  enc_i(6'h08, 5'd2, 5'd0, 16'd2),
                   enc_r(6'h2A, 5'd3, 5'd1, 5'd2),       32'd1};
        vt[5]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'd2),     enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD),
                   enc_r(6'h2A, 5'd3, 5'd1, 5'd2),       32'd0};
        vt[6]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'hFFFF),  enc_i(6'h08, 5'd2, 5'd0, 16'd1),
                   enc_r(6'h20, 5'd3, 5'd1, 5'd2),       32'd0};
        vt[7]  = '{enc_i(6'h08, 5'd3, 5'd0, 16'd6),     enc_i(6'h10, 5'd3, 5'd0, 16'd1),
                   32'h0,                                32'd6};
        vt[8]  = '{enc_i(6'h08, 5'd0, 5'd0, 16'd5),     enc_i(6'h08, 5'd3, 5'd0, 16'd2),
                   enc_r(6'h20, 5'd3, 5'd3, 5'd0),       32'd2};
        vt[9]  = '{enc_i(6'h08, 5'd3, 5'd0, 16'd9),     {6'h02, 26'd3},
                   enc_i(6'h08, 5'd3, 5'd0, 16'd1),     32'd9};
        vt[10] = '{enc_i(6'h08, 5'd3, 5'd0, 16'd4),     enc_i(6'h05, 5'd0, 5'd3, 16'd1),
                   enc_i(6'h08, 5'd3, 5'd0, 16'd1),     32'd4};
        vt[11] = '{enc_i(6'h08, 5'd3, 5'd0, 16'd4),     enc_i(6'h04, 5'd0, 5'd3, 16'd1),
                   enc_i(6'h08, 5'd3, 5'd3, 16'd1),     32'd5};
        vt[12] = '{enc_i(6'h08, 5'd3, 5'd0, 16'hFFF8),  enc_i(6'h08, 5'd3, 5'd3, 16'd16),
                   32'h0,                                32'd8};

        reset   = 1'b1;
        ivalid  = 1'b1;
        wait_en = 1'b0;
        clr_imem();
        imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
        imem[1] = enc_r(6'h20, 5'd2, 5'd1, 5'd1);
        imem[2] = enc_r(6'h22, 5'd3, 5'd2, 5'd1);
        imem[3] = enc_i(6'h2B, 5'd2, 5'd0, 16'd0);
        imem[4] = enc_i(6'h2B, 5'd3, 5'd0, 16'd4);
        imem[5] = HALT;

        #3 reset = 1'b0;
        @(negedge clk);
        chk("rst_imem_addr_fwd", ia0, 32'h0);
        chk("rst_imem_addr_ilk", ia1, 32'h0);
        chk("rst_retire_valid", {31'd0, rv0}, 32'd0);
        chk("rst_halted", {31'd0, h0}, 32'd0);
        chk("rst_dmem_we", {31'd0, dwe0}, 32'd0);
        chk("rst_dmem_re", {31'd0, dre0}, 32'd0);
        chk("rst_retire_pc", rpc0, 32'h0);

        ivalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("imem_invalid_pc_hold", ia0, 32'h0);
        ivalid = 1'b1;
        run("fwd");
        chk("fwd_r2_fwd", dm0[0], 32'd10);
        chk("fwd_r3_fwd", dm0[1], 32'd5);
        chk("fwd_r2_ilk", dm1[0], 32'd10);
        chk("fwd_r3_ilk", dm1[1], 32'd5);
        chk("fwd_gap_add_fwd", rc0[1] - rc0[0], 32'd1);
        chk("fwd_gap_sub_fwd", rc0[2] - rc0[1], 32'd1);
        chk("fwd_gap_add_ilk", rc1[1] - rc1[0], 32'd3);
        chk("fwd_gap_sub_ilk", rc1[2] - rc1[1], 32'd3);

        clr_imem();
        imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd7);
        imem[1] = enc_i(6'h2B, 5'd1, 5'd0, 16'd0);
        imem[2] = enc_i(6'h23, 5'd4, 5'd0, 16'd0);
        imem[3] = enc_r(6'h20, 5'd5, 5'd4, 5'd4);
        imem[4] = enc_i(6'h2B, 5'd5, 5'd0, 16'd4);
        imem[5] = HALT;
        do_reset();
        run("ldu");
        chk("ldu_r5_fwd", dm0[1], 32'd14);
        chk("ldu_r5_ilk", dm1[1], 32'd14);
        chk("ldu_gap_lw", rc0[2] - rc0[1], 32'd1);
        chk("ldu_gap_add", rc0[3] - rc0[2], 32'd2);

        clr_imem();
        imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
        imem[1] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        imem[2] = enc_i(6'h08, 5'd1, 5'd0, 16'd2);
        imem[3] = enc_i(6'h08, 5'd1, 5'd0, 16'd3);
        imem[4] = enc_i(6'h2B, 5'd1, 5'd0, 16'd0);
        imem[5] = HALT;
        do_reset();
        run("br");
        chk("br_skip1", rc0[2], 32'hFFFF_FFFF);
        chk("br_skip2", rc0[3], 32'hFFFF_FFFF);
        chk("br_skip1_ilk", rc1[2], 32'hFFFF_FFFF);
        chk("br_target_gap", rc0[4] - rc0[1], 32'd3);
        chk("br_r1", dm0[0], 32'd1);

        clr_imem();
        imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd9);
        imem[1] = enc_i(6'h2B, 5'd1, 5'd0, 16'd8);
        imem[2] = enc_i(6'h23, 5'd2, 5'd0, 16'd8);
        imem[5] = enc_i(6'h2B, 5'd2, 5'd0, 16'd12);
        imem[6] = HALT;
        wait_en = 1'b1;
        do_reset();
        run("mw");
        chk("mw_wait_cycles", wait_cyc, 32'd3);
        chk("mw_re_held", re_cyc, 32'd4);
        chk("mw_pc_frozen", frz_bad, 32'd0);
        chk("mw_load_fwd", dm0[3], 32'd9);
        chk("mw_load_ilk", dm1[3], 32'd9);
        wait_en = 1'b0;

        for (int v = 0; v < 13; v++) begin
            clr_imem();
            imem[0] = vt[v].i0;
            imem[1] = vt[v].i1;
            imem[2] = vt[v].i2;
            imem[3] = enc_i(6'h2B, 5'd3, 5'd0, 16'd0);
            imem[4] = HALT;
            do_reset();
            run($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_fwd", v), dm0[0], vt[v].exp);
            chk($sformatf("vec%0d_ilk", v), dm1[0], vt[v].exp);
        end

        clr_imem();
        imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
        imem[1] = enc_i(6'h2B, 5'd1, 5'd0, 16'd0);
        imem[2] = HALT;
        do_reset();
        run("hlt");
        chk("hlt_retire_valid", {31'd0, halt_rv}, 32'd1);
        chk("hlt_retire_pc", halt_rpc, 32'd8);
        chk("hlt_r1", dm0[0], 32'd1);
        pc_snap = ia0;
        repeat (10) @(negedge clk);
        chk("hlt_pc_const", ia0, pc_snap);
        chk("hlt_no_retire", {31'd0, rv0}, 32'd0);
        chk("hlt_still_halted", {31'd0, h0}, 32'd1);

        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pc", ia0, 32'h0);
        chk("mid_rst_halted", {31'd0, h0}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run("rerun");
        chk("rerun_r1", dm0[0], 32'd1);
        chk("rerun_first_retired", {31'd0, rc0[0] >= 0}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
